// File: rtl/cfg_loader_if.sv
// Serial configuration bitstream handshake between a bitstream source and
// the configuration loader. A bit moves on a rising edge when both
// ser_valid_i and ser_ready_o are high; ser_data_i carries the bit, MSB first.
interface cfg_loader_if;
  logic ser_valid_i;
  logic ser_data_i;
  logic ser_ready_o;

  // Bitstream source side
  modport master (
    output ser_valid_i,
    output ser_data_i,
    input  ser_ready_o
  );

  // Loader side
  modport slave (
    input  ser_valid_i,
    input  ser_data_i,
    output ser_ready_o
  );
endinterface

// File: rtl/cfg_loader.sv
// Configuration loader for the CLB array.
// Receives a serial bitstream (8-bit sync header followed by NUM_CLB frames
// of CFG_W data bits plus one even-parity bit), checks header and parity,
// and writes each frame to its CLB through a shared bits_o bus qualified by
// a one-cycle one-hot wr_en_o strobe. A whole array is programmed per pass.
module cfg_loader #(
  parameter int unsigned NUM_CLB = 4,
  parameter int unsigned CFG_W   = 23,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  cfg_loader_if.slave        ser,
  output logic [CFG_W-1:0]   bits_o,
  output logic [NUM_CLB-1:0] wr_en_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  // Bit counter only has to reach the longer of the header and a data field.
  localparam int unsigned CNT_MAX = (CFG_W > 8) ? CFG_W : 8;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned IDX_W   = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1;

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(CFG_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CLB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_PAR,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]   bit_cnt;
  logic [IDX_W-1:0]   idx;
  // Only 7 header bits are stored; the 8th is compared straight off the wire.
  logic [6:0]         hdr_sr;
  logic [CFG_W-1:0]   data_sr;

  logic               xfer;
  logic               hdr_ok;
  logic               par_ok;
  logic [NUM_CLB-1:0] onehot;

  logic               clr_cnt;
  logic               inc_cnt;
  logic               clr_idx;
  logic               inc_idx;
  logic               shift_hdr;
  logic               shift_data;
  logic               load_word;

  // Status outputs are pure decodes of the state register, so reset clears
  // them immediately and done/err remain levels until the state changes.
  assign ser.ser_ready_o = (state == S_HDR) || (state == S_DATA) || (state == S_PAR);
  assign busy_o          = ser.ser_ready_o || (state == S_WRITE);
  assign done_o          = (state == S_DONE);
  assign err_o           = (state == S_ERR);

  assign xfer   = ser.ser_valid_i && ser.ser_ready_o;
  assign hdr_ok = ({hdr_sr, ser.ser_data_i} == SYNC);
  assign par_ok = ((^data_sr) == ser.ser_data_i);
  assign onehot = NUM_CLB'(1) << idx;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode and datapath control strobes
  always_comb begin
    state_n    = state;
    clr_cnt    = 1'b0;
    inc_cnt    = 1'b0;
    clr_idx    = 1'b0;
    inc_idx    = 1'b0;
    shift_hdr  = 1'b0;
    shift_data = 1'b0;
    load_word  = 1'b0;

    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          clr_cnt = 1'b1;
          clr_idx = 1'b1;
          state_n = S_HDR;
        end
      end

      S_HDR: begin
        if (xfer) begin
          shift_hdr = 1'b1;
          if (bit_cnt == HDR_LAST) begin
            clr_cnt = 1'b1;
            state_n = hdr_ok ? S_DATA : S_ERR;
          end else begin
            inc_cnt = 1'b1;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          shift_data = 1'b1;
          if (bit_cnt == DATA_LAST) begin
            clr_cnt = 1'b1;
            state_n = S_PAR;
          end else begin
            inc_cnt = 1'b1;
          end
        end
      end

      S_PAR: begin
        if (xfer) begin
          if (par_ok) begin
            load_word = 1'b1;
            state_n   = S_WRITE;
          end else begin
            state_n   = S_ERR;
          end
        end
      end

      S_WRITE: begin
        if (idx == IDX_LAST) begin
          state_n = S_DONE;
        end else begin
          inc_idx = 1'b1;
          state_n = S_DATA;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Counters, shift registers and the registered CLB write port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt <= '0;
      idx     <= '0;
      hdr_sr  <= '0;
      data_sr <= '0;
      bits_o  <= '0;
      wr_en_o <= '0;
    end else begin
      if (clr_cnt) begin
        bit_cnt <= '0;
      end else if (inc_cnt) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (clr_idx) begin
        idx <= '0;
      end else if (inc_idx) begin
        idx <= idx + IDX_W'(1);
      end

      if (shift_hdr) begin
        hdr_sr <= {hdr_sr[5:0], ser.ser_data_i};
      end

      if (shift_data) begin
        data_sr <= (data_sr << 1) | CFG_W'(ser.ser_data_i);
      end

      // bits_o is only updated by a good frame and keeps its word across passes.
      if (load_word) begin
        bits_o <= data_sr;
      end

      // Strobe is registered together with bits_o so it is high for exactly
      // the WRITE cycle and only ever carries a single bit.
      wr_en_o <= load_word ? onehot : '0;
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader: drives serial bitstreams through the
// handshake interface, records every CLB write strobe and compares it with
// the writes expected from the stimulus.
module tb_cfg_loader;
  localparam int unsigned NUM_CLB = 4;
  localparam int unsigned CFG_W   = 23;
  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam int unsigned PASS_CYCLES = 8 + NUM_CLB * (CFG_W + 2);

  typedef logic [NUM_CLB+CFG_W-1:0] wr_t;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [CFG_W-1:0]   bits;
  logic [NUM_CLB-1:0] wr_en;
  logic               busy;
  logic               done;
  logic               err;

  cfg_loader_if sif ();

  cfg_loader #(
    .NUM_CLB (NUM_CLB),
    .CFG_W   (CFG_W),
    .SYNC    (SYNC)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .ser     (sif),
    .bits_o  (bits),
    .wr_en_o (wr_en),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned strobe_viol = 0;
  bit          timed_out = 1'b0;

  wr_t exp_q[$];
  wr_t obs_q[$];

  logic [CFG_W-1:0] clb_cfg [NUM_CLB];
  logic [CFG_W-1:0] words   [NUM_CLB];
  logic             pars    [NUM_CLB];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream CLB registers capture bits_o on the edge that ends WRITE
  always @(posedge clk) begin
    for (int k = 0; k < NUM_CLB; k++) begin
      if (wr_en[k]) clb_cfg[k] <= bits;
    end
  end

  // Write monitor: records strobes and flags non-one-hot or out-of-WRITE strobes
  always @(negedge clk) begin
    if (wr_en !== '0) begin
      obs_q.push_back({wr_en, bits});
      if ($countones(wr_en) != 1 || sif.ser_ready_o || done || err || !busy)
        strobe_viol <= strobe_viol + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Drives one bit; returns #1 after the edge that accepted it
  task automatic send_bit(input logic b, input bit stall);
    int unsigned guard = 0;
    bit go;
    if (timed_out) return;
    forever begin
      go = !stall || ($urandom_range(1, 0) == 1);
      sif.ser_valid_i = go;
      sif.ser_data_i  = b;
      if (go && sif.ser_ready_o === 1'b1) begin
        @(posedge clk); #1;
        sif.ser_valid_i = 1'b0;
        return;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 64) begin
        checks++; errors++;
        $display("FAIL send_bit_timeout: ser_ready_o=%b after %0d cycles, required 1", sif.ser_ready_o, guard);
        timed_out = 1'b1;
        sif.ser_valid_i = 1'b0;
        return;
      end
    end
  endtask

  task automatic send_hdr(input logic [7:0] h, input bit stall);
    for (int i = 7; i >= 0; i--) send_bit(h[i], stall);
  endtask

  task automatic send_frame(input logic [CFG_W-1:0] w, input logic p, input bit stall);
    for (int i = CFG_W - 1; i >= 0; i--) send_bit(w[i], stall);
    send_bit(p, stall);
  endtask

  task automatic do_start(output int unsigned t0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(output int unsigned t1, output bit seen);
    seen = 1'b0;
    t1 = 0;
    for (int i = 0; i < 16; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        t1 = cyc;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sif.ser_valid_i = 1'b0;
    sif.ser_data_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bits !== '0) begin errors++; $display("FAIL reset_bits: got %h, required 0", bits); end
    checks++;
    if (wr_en !== '0) begin errors++; $display("FAIL reset_wr_en: got %b, required 0", wr_en); end
    checks++;
    if ({sif.ser_ready_o, busy, done, err} !== 4'b0000) begin
      errors++; $display("FAIL reset_status: ready/busy/done/err=%b, required 0000", {sif.ser_ready_o, busy, done, err});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sif.ser_ready_o, busy, done, err} !== 4'b0000) begin
      errors++; $display("FAIL idle_after_reset: ready/busy/done/err=%b, required 0000", {sif.ser_ready_o, busy, done, err});
    end
  endtask

  task automatic test_nominal;
    int unsigned t0, t1;
    bit seen;
    logic [NUM_CLB-1:0] oh;
    wr_t e, o;
    exp_q.delete(); obs_q.delete();
    do_start(t0);
    checks++;
    if (sif.ser_ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_start: got %b, required 1", sif.ser_ready_o); end
    send_hdr(SYNC, 1'b0);
    for (int k = 0; k < NUM_CLB; k++) begin
      oh = NUM_CLB'(1) << k;
      exp_q.push_back({oh, words[k]});
      send_frame(words[k], pars[k], 1'b0);
      checks++;
      if (wr_en !== oh || bits !== words[k]) begin
        errors++; $display("FAIL nominal_strobe%0d: wr_en=%b bits=%h, required wr_en=%b bits=%h", k, wr_en, bits, oh, words[k]);
      end
      checks++;
      if (sif.ser_ready_o !== 1'b0) begin errors++; $display("FAIL write_bubble%0d: ready=%b, required 0", k, sif.ser_ready_o); end
    end
    wait_done(t1, seen);
    checks++;
    if (!seen || (t1 - t0) != PASS_CYCLES) begin
      errors++; $display("FAIL done_latency: seen=%0d cycles=%0d, required seen=1 cycles=%0d", seen, t1 - t0, PASS_CYCLES);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL nominal_write_count: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL nominal_write: got %h, required %h", o, e); end
    end
    for (int k = 0; k < NUM_CLB; k++) begin
      checks++;
      if (clb_cfg[k] !== words[k]) begin errors++; $display("FAIL clb_cfg%0d: got %h, required %h", k, clb_cfg[k], words[k]); end
    end
    checks++;
    if ({sif.ser_ready_o, busy, err} !== 3'b000) begin
      errors++; $display("FAIL done_status: ready/busy/err=%b, required 000", {sif.ser_ready_o, busy, err});
    end
  endtask

  task automatic test_bad_header;
    int unsigned t0;
    exp_q.delete(); obs_q.delete();
    do_start(t0);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_cleared_on_start: got %b, required 0", done); end
    send_hdr(8'hA4, 1'b0);
    checks++;
    if ({err, sif.ser_ready_o, busy} !== 3'b100) begin
      errors++; $display("FAIL bad_header_status: err/ready/busy=%b, required 100", {err, sif.ser_ready_o, busy});
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 0 || err !== 1'b1) begin
      errors++; $display("FAIL bad_header_writes: writes=%0d err=%b, required writes=0 err=1", obs_q.size(), err);
    end
  endtask

  task automatic test_parity_err;
    int unsigned t0;
    logic [NUM_CLB-1:0] oh;
    wr_t e, o;
    exp_q.delete(); obs_q.delete();
    do_start(t0);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_cleared_on_start: got %b, required 0", err); end
    send_hdr(SYNC, 1'b0);
    for (int k = 0; k < 2; k++) begin
      oh = NUM_CLB'(1) << k;
      exp_q.push_back({oh, words[k]});
      send_frame(words[k], pars[k], 1'b0);
    end
    send_frame(words[2], ~pars[2], 1'b0);
    checks++;
    if ({err, busy, wr_en} !== {1'b1, 1'b0, {NUM_CLB{1'b0}}}) begin
      errors++; $display("FAIL parity_err_status: err=%b busy=%b wr_en=%b, required err=1 busy=0 wr_en=0", err, busy, wr_en);
    end
    checks++;
    if (bits !== words[1]) begin errors++; $display("FAIL parity_err_bits: got %h, required %h", bits, words[1]); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL parity_write_count: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL parity_write: got %h, required %h", o, e); end
    end
  endtask

  task automatic test_stalls;
    int unsigned t0, t1;
    bit seen;
    logic [NUM_CLB-1:0] oh;
    wr_t e, o;
    exp_q.delete(); obs_q.delete();
    do_start(t0);
    checks++;
    if (bits !== words[1]) begin errors++; $display("FAIL bits_kept_on_start: got %h, required %h", bits, words[1]); end
    send_hdr(SYNC, 1'b1);
    for (int k = 0; k < NUM_CLB; k++) begin
      oh = NUM_CLB'(1) << k;
      exp_q.push_back({oh, words[k]});
      send_frame(words[k], pars[k], 1'b1);
    end
    wait_done(t1, seen);
    checks++;
    if (!seen || err !== 1'b0) begin errors++; $display("FAIL stall_done: done_seen=%0d err=%b, required 1 0", seen, err); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL stall_write_count: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL stall_write: got %h, required %h", o, e); end
    end
  endtask

  task automatic test_restart;
    int unsigned t0, t1;
    bit seen;
    logic [NUM_CLB-1:0] oh;
    wr_t e, o;
    for (int pass = 0; pass < 2; pass++) begin
      exp_q.delete(); obs_q.delete();
      do_start(t0);
      checks++;
      if ({done, busy, sif.ser_ready_o} !== 3'b011) begin
        errors++; $display("FAIL restart%0d_status: done/busy/ready=%b, required 011", pass, {done, busy, sif.ser_ready_o});
      end
      send_hdr(SYNC, 1'b0);
      for (int k = 0; k < NUM_CLB; k++) begin
        oh = NUM_CLB'(1) << k;
        exp_q.push_back({oh, words[k]});
        if (k == 1) begin
          for (int i = CFG_W - 1; i >= 0; i--) begin
            if (i == 10) start = 1'b1;
            send_bit(words[k][i], 1'b0);
            start = 1'b0;
          end
          send_bit(pars[k], 1'b0);
        end else begin
          send_frame(words[k], pars[k], 1'b0);
        end
      end
      wait_done(t1, seen);
      checks++;
      if (!seen || (t1 - t0) != PASS_CYCLES) begin
        errors++; $display("FAIL restart%0d_latency: seen=%0d cycles=%0d, required seen=1 cycles=%0d", pass, seen, t1 - t0, PASS_CYCLES);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL restart%0d_write_count: got %0d, required %0d", pass, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL restart%0d_write: got %h, required %h", pass, o, e); end
      end
    end
  endtask

  task automatic test_reset_midpass;
    int unsigned t0;
    exp_q.delete(); obs_q.delete();
    do_start(t0);
    send_hdr(SYNC, 1'b0);
    send_frame(words[0], pars[0], 1'b0);
    checks++;
    if (wr_en !== 4'b0001) begin errors++; $display("FAIL midpass_strobe: got %b, required 0001", wr_en); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, bits} !== '0) begin
      errors++; $display("FAIL midpass_reset_bus: wr_en=%b bits=%h, required 0 0", wr_en, bits);
    end
    checks++;
    if ({sif.ser_ready_o, busy, done, err} !== 4'b0000) begin
      errors++; $display("FAIL midpass_reset_status: ready/busy/done/err=%b, required 0000", {sif.ser_ready_o, busy, done, err});
    end
    @(negedge clk) rst_n = 1'b1;
    sif.ser_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sif.ser_valid_i = 1'b0;
    checks++;
    if ({sif.ser_ready_o, busy, done, err} !== 4'b0000 || obs_q.size() != 0) begin
      errors++; $display("FAIL midpass_no_resume: ready/busy/done/err=%b writes=%0d, required 0000 0",
                         {sif.ser_ready_o, busy, done, err}, obs_q.size());
    end
  endtask

  initial begin
    words[0] = 23'h035237; pars[0] = 1'b0;
    words[1] = 23'h365A37; pars[1] = 1'b1;
    words[2] = 23'h78FF00; pars[2] = 1'b0;
    words[3] = 23'h000000; pars[3] = 1'b0;
    sif.ser_valid_i = 1'b0;
    sif.ser_data_i  = 1'b0;

    test_reset();
    test_nominal();
    test_bad_header();
    test_parity_err();
    test_stalls();
    test_restart();
    test_reset_midpass();

    checks++;
    if (strobe_viol != 0) begin errors++; $display("FAIL strobe_shape: %0d bad strobe cycles, required 0", strobe_viol); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
